// File: rtl/osd_mam_if_arb_if.sv
// rtl/osd_mam_if_arb_if.sv - MAM request/write/read channel bundle with master and slave views
interface osd_mam_if_arb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_rw;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      req_burst;
    logic [13:0]               req_beats;

    logic                      write_valid;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   write_strb;
    logic                      write_ready;

    logic                      read_valid;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      read_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
        output write_valid, write_data, write_strb,
        output read_ready,
        input  req_ready, write_ready, read_valid, read_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
        input  write_valid, write_data, write_strb,
        input  read_ready,
        output req_ready, write_ready, read_valid, read_data
    );
endinterface

// File: rtl/osd_mam_if_arb.sv
// rtl/osd_mam_if_arb.sv - two-port round-robin arbiter onto one MAM memory interface
module osd_mam_if_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    osd_mam_if_arb_if.slave      s0,
    osd_mam_if_arb_if.slave      s1,
    osd_mam_if_arb_if.master     m,
    output logic [1:0]           grant,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                  state, state_next;
    logic                    owner;
    logic                    rr_last;
    logic [13:0]             beat_cnt;
    logic                    sel;
    logic                    req_fire, wr_fire, rd_fire;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [13:0]             sel_beats;
    logic [13:0]             beat_load;
    logic [DATA_WIDTH-1:0]   own_wdata;
    logic [DATA_WIDTH/8-1:0] own_wstrb;

    // Pick the requester: a lone valid wins, otherwise alternate away from the last winner
    always_comb begin
        sel       = (s0.req_valid ^ s1.req_valid) ? s1.req_valid : ~rr_last;
        sel_addr  = sel ? s1.req_addr  : s0.req_addr;
        sel_beats = sel ? s1.req_beats : s0.req_beats;
        beat_load = ((sel ? s1.req_burst : s0.req_burst) && (sel_beats != 14'd0)) ? sel_beats : 14'd1;
        own_wdata = owner ? s1.write_data : s0.write_data;
        own_wstrb = owner ? s1.write_strb : s0.write_strb;
    end

    // Route handshakes between the selected/owning port and the master side
    always_comb begin
        m.req_valid    = 1'b0;
        m.req_rw       = sel ? s1.req_rw : s0.req_rw;
        m.req_addr     = sel_addr;
        m.req_burst    = sel ? s1.req_burst : s0.req_burst;
        m.req_beats    = sel_beats;
        m.write_valid  = 1'b0;
        m.write_data   = own_wdata;
        m.write_strb   = own_wstrb;
        m.read_ready   = 1'b0;
        s0.req_ready   = 1'b0;
        s1.req_ready   = 1'b0;
        s0.write_ready = 1'b0;
        s1.write_ready = 1'b0;
        s0.read_valid  = 1'b0;
        s1.read_valid  = 1'b0;
        s0.read_data   = m.read_data;
        s1.read_data   = m.read_data;
        case (state)
            IDLE: begin
                // Reset forces IDLE asynchronously; gating here drops every valid/ready at once
                if (!rst_i) begin
                    m.req_valid = sel ? s1.req_valid : s0.req_valid;
                    if (sel) s1.req_ready = m.req_ready;
                    else     s0.req_ready = m.req_ready;
                end
            end
            WRITE: begin
                m.write_valid = owner ? s1.write_valid : s0.write_valid;
                if (owner) s1.write_ready = m.write_ready;
                else       s0.write_ready = m.write_ready;
            end
            READ: begin
                m.read_ready = owner ? s1.read_ready : s0.read_ready;
                if (owner) s1.read_valid = m.read_valid;
                else       s0.read_valid = m.read_valid;
            end
            default: ;
        endcase
    end

    // Handshake strobes and status outputs
    always_comb begin
        req_fire = m.req_valid & m.req_ready;
        wr_fire  = m.write_valid & m.write_ready;
        rd_fire  = m.read_valid & m.read_ready;
        busy     = (state != IDLE);
        grant    = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    end

    // Next-state: lock on an accepted request, release after the last beat
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire) state_next = m.req_rw ? WRITE : READ;
            WRITE:   if (wr_fire && beat_cnt <= 14'd1) state_next = IDLE;
            READ:    if (rd_fire && beat_cnt <= 14'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, ownership, round-robin history and beat counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_last  <= 1'b1;
            beat_cnt <= 14'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_fire) begin
                owner    <= sel;
                rr_last  <= sel;
                beat_cnt <= beat_load;
            end else if (((state == WRITE && wr_fire) || (state == READ && rd_fire))
                         && beat_cnt != 14'd0) begin
                beat_cnt <= beat_cnt - 14'd1;
            end
        end
    end
endmodule

// File: tb/tb_osd_mam_if_arb.sv
// tb/tb_osd_mam_if_arb.sv - directed self-checking bench for osd_mam_if_arb
module tb_osd_mam_if_arb;
    logic       clk;
    logic       rst_i;
    logic [1:0] grant;
    logic       busy;
    int         n_checks;
    int         n_fail;
    int         hs;

    osd_mam_if_arb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) s0_bus ();
    osd_mam_if_arb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) s1_bus ();
    osd_mam_if_arb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) m_bus ();

    osd_mam_if_arb #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .s0    (s0_bus),
        .s1    (s1_bus),
        .m     (m_bus),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic v, input logic rw,
                           input logic [31:0] addr, input logic burst, input logic [13:0] beats);
        if (port == 0) begin
            s0_bus.req_valid = v; s0_bus.req_rw = rw; s0_bus.req_addr = addr;
            s0_bus.req_burst = burst; s0_bus.req_beats = beats;
        end else begin
            s1_bus.req_valid = v; s1_bus.req_rw = rw; s1_bus.req_addr = addr;
            s1_bus.req_burst = burst; s1_bus.req_beats = beats;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        s0_bus.write_valid = 0; s0_bus.write_data = 0; s0_bus.write_strb = 0; s0_bus.read_ready = 0;
        s1_bus.write_valid = 0; s1_bus.write_data = 0; s1_bus.write_strb = 0; s1_bus.read_ready = 0;
        m_bus.req_ready = 1; m_bus.write_ready = 0; m_bus.read_valid = 0; m_bus.read_data = 0;

        // Reset state: outputs quiet even with a requester and ready master
        s0_bus.req_valid = 1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_s0_req_ready", s0_bus.req_ready, 0);
        check("rst_m_req_valid", m_bus.req_valid, 0);
        s0_bus.req_valid = 0;
        rst_i = 0;
        #1;

        // Single write from s0
        set_req(0, 1, 1, 32'h100, 0, 0);
        #1;
        check("wr_m_addr", m_bus.req_addr, 32'h100);
        check("wr_m_req_valid", m_bus.req_valid, 1);
        check("wr_s0_req_ready", s0_bus.req_ready, 1);
        check("wr_s1_req_ready", s1_bus.req_ready, 0);
        check("wr_idle_m_wvalid", m_bus.write_valid, 0);
        tick();
        s0_bus.req_valid = 0;
        check("wr_grant", grant, 2'b01);
        check("wr_busy", busy, 1);
        s0_bus.write_valid = 1; s0_bus.write_data = 16'hABCD; s0_bus.write_strb = 2'b11;
        m_bus.write_ready = 1;
        #1;
        check("wr_m_wdata", m_bus.write_data, 16'hABCD);
        check("wr_m_wstrb", m_bus.write_strb, 2'b11);
        check("wr_s0_wready", s0_bus.write_ready, 1);
        check("wr_s1_wready", s1_bus.write_ready, 0);
        tick();
        s0_bus.write_valid = 0; m_bus.write_ready = 0;
        check("wr_done_busy", busy, 0);
        check("wr_done_grant", grant, 0);

        // Tie after reset goes to s0, then s1, then s0 again
        do_reset();
        set_req(0, 1, 0, 32'h200, 0, 0);
        set_req(1, 1, 0, 32'h300, 0, 0);
        #1;
        check("tie1_s0_ready", s0_bus.req_ready, 1);
        check("tie1_s1_ready", s1_bus.req_ready, 0);
        check("tie1_addr", m_bus.req_addr, 32'h200);
        tick();
        s0_bus.req_valid = 0;
        check("tie1_grant", grant, 2'b01);
        check("tie1_s1_held", s1_bus.req_ready, 0);
        m_bus.read_valid = 1; m_bus.read_data = 16'h1234;
        s0_bus.read_ready = 1; s1_bus.read_ready = 1;
        #1;
        check("tie1_s0_rvalid", s0_bus.read_valid, 1);
        check("tie1_s1_rvalid", s1_bus.read_valid, 0);
        check("tie1_bcast", s1_bus.read_data, 16'h1234);
        check("tie1_m_rready", m_bus.read_ready, 1);
        tick();
        m_bus.read_valid = 0;
        #1;
        check("tie2_busy", busy, 0);
        check("tie2_s1_ready", s1_bus.req_ready, 1);
        tick();
        s1_bus.req_valid = 0;
        check("tie2_grant", grant, 2'b10);
        m_bus.read_valid = 1;
        #1;
        check("tie2_s1_rvalid", s1_bus.read_valid, 1);
        check("tie2_s0_rvalid", s0_bus.read_valid, 0);
        tick();
        m_bus.read_valid = 0;
        set_req(0, 1, 0, 32'h400, 0, 0);
        set_req(1, 1, 0, 32'h500, 0, 0);
        #1;
        check("tie3_s0_ready", s0_bus.req_ready, 1);
        check("tie3_s1_ready", s1_bus.req_ready, 0);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        check("tie3_grant", grant, 2'b01);
        m_bus.read_valid = 1;
        tick();
        m_bus.read_valid = 0;
        check("tie3_done", busy, 0);

        // Burst read of 4 beats to s1 with one stalled cycle
        set_req(1, 1, 0, 32'h600, 1, 14'd4);
        tick();
        s1_bus.req_valid = 0;
        check("br_grant", grant, 2'b10);
        m_bus.read_valid = 1;
        for (int i = 0; i < 5; i++) begin
            s1_bus.read_ready = (i != 2);
            #1;
            check("br_busy", busy, 1);
            check("br_s0_rvalid", s0_bus.read_valid, 0);
            check("br_s1_rvalid", s1_bus.read_valid, 1);
            check("br_m_rready", m_bus.read_ready, (i != 2));
            tick();
        end
        m_bus.read_valid = 0;
        s1_bus.read_ready = 1;
        check("br_done_busy", busy, 0);
        check("br_done_grant", grant, 0);

        // Burst with zero beats behaves as a single beat
        set_req(0, 1, 1, 32'h700, 1, 14'd0);
        tick();
        s0_bus.req_valid = 0;
        check("z_busy", busy, 1);
        s0_bus.write_valid = 1; m_bus.write_ready = 1;
        tick();
        s0_bus.write_valid = 0; m_bus.write_ready = 0;
        check("z_done_busy", busy, 0);

        // 8-beat write from s0 with backpressure; s1 locked out until done
        set_req(0, 1, 1, 32'h800, 1, 14'd8);
        tick();
        s0_bus.req_valid = 0;
        check("bp_grant", grant, 2'b01);
        set_req(1, 1, 0, 32'h900, 0, 0);
        s0_bus.write_valid = 1;
        hs = 0;
        for (int cyc = 0; cyc < 40 && hs < 8; cyc++) begin
            m_bus.write_ready = (cyc % 2 == 0);
            #1;
            check("bp_busy", busy, 1);
            check("bp_s1_ready", s1_bus.req_ready, 0);
            check("bp_m_req_valid", m_bus.req_valid, 0);
            if (m_bus.write_valid && m_bus.write_ready) hs++;
            tick();
        end
        s0_bus.write_valid = 0; m_bus.write_ready = 0;
        check("bp_beats", hs, 8);
        check("bp_done_busy", busy, 0);
        check("bp_s1_ready_after", s1_bus.req_ready, 1);
        tick();
        s1_bus.req_valid = 0;
        check("bp_s1_grant", grant, 2'b10);
        m_bus.read_valid = 1;
        tick();
        m_bus.read_valid = 0;
        check("bp_s1_done", busy, 0);

        // Reset in the middle of a 4-beat read
        set_req(0, 1, 0, 32'hA00, 1, 14'd4);
        tick();
        s0_bus.req_valid = 0;
        m_bus.read_valid = 1;
        tick();
        tick();
        rst_i = 1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_grant", grant, 0);
        check("mr_s0_rvalid", s0_bus.read_valid, 0);
        check("mr_m_rready", m_bus.read_ready, 0);
        m_bus.read_valid = 0;
        rst_i = 0;
        #1;
        set_req(0, 1, 1, 32'hB00, 0, 0);
        #1;
        check("mr_s0_req_ready", s0_bus.req_ready, 1);
        tick();
        s0_bus.req_valid = 0;
        check("mr_new_grant", grant, 2'b01);
        s0_bus.write_valid = 1; m_bus.write_ready = 1;
        tick();
        s0_bus.write_valid = 0; m_bus.write_ready = 0;
        check("mr_new_done", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/osd_mam_if_arb.md
OSD_MAM_IF_ARB -- requirements
Module: osd_mam_if_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data width in bits, a multiple of 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have, per upstream port n in {0,1}, the following slave-side ports: sN_req_valid in 1, sN_req_ready out 1, sN_req_rw in 1, sN_req_addr in ADDR_WIDTH, sN_req_burst in 1, sN_req_beats in 14.
REQ-006 SHALL have, per upstream port n in {0,1}, the following slave-side ports: sN_write_valid in 1, sN_write_data in DATA_WIDTH, sN_write_strb in DATA_WIDTH/8, sN_write_ready out 1, sN_read_valid out 1, sN_read_data out DATA_WIDTH, sN_read_ready in 1.
REQ-007 SHALL have a master-side port set towards the MAM memory interface, with the same signal names prefixed m_ and opposite directions.
REQ-008 SHALL have port grant  output  2  one-hot index of the port that currently owns the master side; 0 when idle.
REQ-009 SHALL have port busy  output  1  high while a transaction is locked.

Function
REQ-010 SHALL implement three states: IDLE, WRITE, READ.
REQ-011 In IDLE, port selection SHALL be as follows: one valid requester is selected; if both are valid, the port not granted last (rr_last) is selected; if neither is valid, the selection is rr_last inverted.
REQ-012 In IDLE, m_req_* SHALL be driven from the selected port combinationally; the selected port's sN_req_ready SHALL equal m_req_ready; the other port's sN_req_ready SHALL be 0.
REQ-013 In IDLE, m_write_valid SHALL be 0, m_read_ready SHALL be 0, and all sN_write_ready and sN_read_valid SHALL be 0.
REQ-014 On an accepted request (m_req_valid and m_req_ready) in IDLE, the arbiter SHALL register the owner, set rr_last to the owner, and load beat_cnt.
REQ-015 The beat_cnt load value SHALL be req_beats if req_burst=1 and req_beats!=0, and 1 otherwise (req_beats=0 is treated as 1).
REQ-016 On an accepted request in IDLE, the next state SHALL be WRITE if req_rw=1, and READ if req_rw=0.
REQ-017 In WRITE, the owner's write channel SHALL connect straight through to m_write_*: valid, data, strb forward; ready back.
REQ-018 In WRITE, beat_cnt SHALL decrement on each m_write_valid and m_write_ready; the handshake with beat_cnt=1 SHALL return to IDLE on the next cycle.
REQ-019 In READ, m_read_valid SHALL route to the owner's sN_read_valid and the owner's sN_read_ready SHALL route to m_read_ready.
REQ-020 In READ, beat_cnt SHALL decrement on each m_read_valid and m_read_ready; the handshake with beat_cnt=1 SHALL return to IDLE.
REQ-021 m_read_data SHALL be broadcast to both sN_read_data at all times; valid SHALL only ever assert towards the owner.
REQ-022 In WRITE and READ, m_req_valid SHALL be 0 and both sN_req_ready SHALL be 0; new requests SHALL wait with no preemption.
REQ-023 Combinational latency SHALL be zero on all routed handshakes; the arbitration decision SHALL take effect from the cycle after the previous transaction completes, adding no idle gap beyond that.
REQ-024 A request raised by the non-owner during a transaction SHALL be held pending and granted first at the next IDLE if the owner is not also requesting, or by round-robin if it is.
REQ-025 beat_cnt SHALL be 14 bits wide; it SHALL never underflow and SHALL never be decremented in IDLE.
REQ-026 busy SHALL be 1 exactly in WRITE and READ; grant SHALL be the one-hot owner in WRITE and READ, and 0 in IDLE.

Reset
REQ-027 While rst_i=1 (asynchronous), the state SHALL be IDLE, beat_cnt SHALL be 0, the owner SHALL be 0, rr_last SHALL be 1 so that port 0 wins the first tie, busy SHALL be 0, and grant SHALL be 0.
REQ-028 A reset mid-transaction SHALL abort it immediately; all ready and valid outputs SHALL drop during reset; no residual beat count SHALL survive the reset.

Verification
REQ-029 Single write: s0 request rw=1, burst=0, addr=0x100 -> m_req_addr=0x100; one write beat passes; grant=01 for the transfer; IDLE after the beat.
REQ-030 Tie after reset: s0 and s1 request reads together -> s0 is granted first; after its read beat, s1 is granted; a further tie then goes to s0.
REQ-031 Burst read: s1 request burst=1, beats=4 -> exactly 4 read handshakes routed to s1 with s0_read_valid=0 throughout; busy drops after the 4th handshake.
REQ-032 Zero beats: burst=1, beats=0 -> treated as a single beat; the arbiter returns to IDLE after 1 handshake.
REQ-033 Backpressure and lockout: during an s0 8-beat write with m_write_ready toggling, s1 raises a request -> s1_req_ready=0 until the 8th beat completes, then s1 is granted.
REQ-034 Reset mid-burst: rst_i asserted after 2 of 4 beats -> busy=0 and grant=0 immediately; a following request from s0 is accepted normally.
